// File: rtl/axis_fifo_wr_arbiter.sv
// Packet-granular round-robin scheduler sharing one async-FIFO write port among
// NUM_REQ AXI-Stream requesters; each granted packet is preceded by a source-ID header word.
module axis_fifo_wr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOGIC_SIZE  = 8,
  parameter int MAX_PKT_LEN = 256,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          i_wclk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ*LOGIC_SIZE-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic                          o_fifo_wr,
  output logic [LOGIC_SIZE-1:0]         o_fifo_wdata,
  input  logic                          i_fifo_wfull,
  output logic                          o_busy,
  output logic [ID_W-1:0]               o_grant_id,
  output logic                          o_err_trunc
);

  localparam int CNT_W = (MAX_PKT_LEN > 0) ? $clog2(MAX_PKT_LEN + 1) : 1;
  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       winner;
  logic                  win_found;
  logic [CNT_W-1:0]      beat_cnt;
  logic [CNT_W:0]        beat_nxt;
  logic [LOGIC_SIZE-1:0] g_data;
  logic                  g_valid;
  logic                  g_last;
  logic                  beat;

  // Round-robin search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!win_found && s_tvalid[(int'(last_grant) + i) % NUM_REQ]) begin
        win_found = 1'b1;
        winner    = ID_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign g_data   = s_tdata[int'(o_grant_id)*LOGIC_SIZE +: LOGIC_SIZE];
  assign g_valid  = s_tvalid[o_grant_id];
  assign g_last   = s_tlast[o_grant_id];
  assign beat     = (state == DATA) && g_valid && !i_fifo_wfull;
  assign beat_nxt = {1'b0, beat_cnt} + (CNT_W + 1)'(1);
  assign o_busy   = (state != IDLE);

  // Handshake: a beat transfers on a cycle where tvalid and tready are both high; tready is
  // only ever offered to the granted requester in DATA and follows !wfull combinationally,
  // so the FIFO write and the requester's acceptance happen on the same edge.
  always_comb begin
    s_tready     = '0;
    o_fifo_wr    = 1'b0;
    o_fifo_wdata = '0;
    case (state)
      HDR: begin
        o_fifo_wr    = !i_fifo_wfull;
        o_fifo_wdata = LOGIC_SIZE'(o_grant_id);
      end
      DATA: begin
        s_tready[o_grant_id] = !i_fifo_wfull;
        o_fifo_wr            = g_valid && !i_fifo_wfull;
        o_fifo_wdata         = g_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      o_grant_id  <= '0;
      o_err_trunc <= 1'b0;
    end else begin
      o_err_trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            o_grant_id <= winner;
            last_grant <= winner;
            state      <= HDR;
          end
        end
        HDR: begin
          if (!i_fifo_wfull) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_nxt[CNT_W-1:0];
            if (g_last) begin
              state <= IDLE;
            end else if (MAX_PKT_LEN != 0 && beat_nxt == LIMIT) begin
              // Remaining beats of a runaway packet re-arbitrate as a fresh packet.
              o_err_trunc <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Bench for axis_fifo_wr_arbiter: randomized AXI-Stream sources and FIFO backpressure,
// checked every cycle against a packet-level reference model of the arbiter.
module tb_axis_fifo_wr_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXL = 4;
  localparam int IDW  = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic           fifo_wr;
  logic [W-1:0]   fifo_wdata;
  logic           wfull;
  logic           busy;
  logic [IDW-1:0] grant_id;
  logic           err_trunc;

  always #5 clk = ~clk;

  axis_fifo_wr_arbiter #(.NUM_REQ(N), .LOGIC_SIZE(W), .MAX_PKT_LEN(MAXL)) dut (
    .i_wclk(clk), .i_rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .o_fifo_wr(fifo_wr), .o_fifo_wdata(fifo_wdata), .i_fifo_wfull(wfull),
    .o_busy(busy), .o_grant_id(grant_id), .o_err_trunc(err_trunc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0]   src_q [N][$];   // {last, data} beats each requester still has to send
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hdr_log[$];

  int m_phase, m_grant, m_last, m_beats, exp_grant;
  bit exp_err;
  int stall_cnt [N];
  bit stall_arm;
  bit acc [N];
  int gap_pct, full_pct, trunc_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_grant   = 0;
    m_last    = N - 1;
    m_beats   = 0;
    exp_grant = 0;
    exp_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic add_pkt(input int k, input int len, input logic [W-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      logic [W-1:0] d;
      d = rnd ? W'($urandom) : base + W'(i);
      src_q[k].push_back({(i == len - 1), d});
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (stall_cnt[k] > 0) stall_cnt[k]--;
      if (s_tvalid[k] && !acc[k]) continue;
      if (src_q[k].size() > 0 && stall_cnt[k] == 0 && $urandom_range(0, 99) >= gap_pct) begin
        s_tvalid[k]        = 1'b1;
        s_tdata[k*W +: W]  = src_q[k][0][W-1:0];
        s_tlast[k]         = src_q[k][0][W];
      end else begin
        s_tvalid[k]        = 1'b0;
        s_tdata[k*W +: W]  = W'($urandom);
        s_tlast[k]         = 1'($urandom);
      end
      acc[k] = 1'b0;
    end
    wfull = ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic evaluate();
    logic [N-1:0] exp_tready;
    logic         exp_wr;
    logic [W:0]   b;
    bit           is_hdr;
    int           w;
    exp_tready = '0;
    exp_wr     = 1'b0;
    is_hdr     = 1'b0;
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    check_eq("grant_id", 32'(grant_id), 32'(exp_grant));
    check_eq("err_trunc", 32'(err_trunc), 32'(exp_err));
    if (err_trunc) trunc_seen++;
    exp_err = 1'b0;
    case (m_phase)
      0: if (s_tvalid != '0) begin
        w = -1;
        for (int i = 1; i <= N; i++) if (w < 0 && s_tvalid[(m_last + i) % N]) w = (m_last + i) % N;
        m_grant = w; m_last = w; exp_grant = w; m_phase = 1;
      end
      1: if (!wfull) begin
        exp_wr = 1'b1; is_hdr = 1'b1;
        exp_q.push_back(W'(m_grant));
        m_beats = 0; m_phase = 2;
      end
      default: begin
        if (!wfull) exp_tready[m_grant] = 1'b1;
        if (s_tvalid[m_grant] && !wfull) begin
          b = src_q[m_grant][0];
          exp_wr = 1'b1;
          exp_q.push_back(b[W-1:0]);
          m_beats++;
          if (b[W]) m_phase = 0;
          else if (m_beats == MAXL) begin exp_err = 1'b1; m_phase = 0; end
        end
      end
    endcase
    check_eq("tready", 32'(s_tready), 32'(exp_tready));
    check_eq("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
    if (fifo_wr) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_wr: got 0x%0h expected no write at %0t", fifo_wdata, $time);
      end else begin
        check_eq("wdata", 32'(fifo_wdata), 32'(exp_q.pop_front()));
      end
      if (is_hdr) hdr_log.push_back(fifo_wdata);
    end
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      acc[k] = s_tvalid[k] && s_tready[k];
      if (acc[k]) begin
        void'(src_q[k].pop_front());
        if (k == 0 && stall_arm) begin stall_cnt[0] = 10; stall_arm = 1'b0; end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    evaluate();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while (!(all_empty() && m_phase == 0)) begin
      if (c >= budget) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d cycles expected idle within %0d", c, budget);
        return;
      end
      cycle();
      c++;
    end
    cycle();
    cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; wfull = 1'b0;
    gap_pct = 0; full_pct = 0; trunc_seen = 0; stall_arm = 1'b0;
    for (int k = 0; k < N; k++) begin stall_cnt[k] = 0; acc[k] = 1'b0; end
    model_reset();

    // reset state
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_tready", 32'(s_tready), 32'h0);
    check_eq("rst_fifo_wr", 32'(fifo_wr), 32'h0);
    check_eq("rst_wdata", 32'(fifo_wdata), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_grant", 32'(grant_id), 32'h0);
    check_eq("rst_err", 32'(err_trunc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // fairness: everyone valid with one-beat packets
    hdr_log.delete();
    for (int k = 0; k < N; k++) begin
      add_pkt(k, 1, W'(8'h10 * (k + 1)), 1'b0);
      add_pkt(k, 1, W'(8'h10 * (k + 1) + 8), 1'b0);
    end
    run_until_idle(100);
    check_eq("rr_hdr_count", 32'(hdr_log.size()), 32'd8);
    check_eq("rr_hdr0", 32'(hdr_log[0]), 32'h00);
    check_eq("rr_hdr1", 32'(hdr_log[1]), 32'h01);
    check_eq("rr_hdr2", 32'(hdr_log[2]), 32'h02);
    check_eq("rr_hdr3", 32'(hdr_log[3]), 32'h03);
    check_eq("rr_hdr4", 32'(hdr_log[4]), 32'h00);

    // single requester, 3 beats
    hdr_log.delete();
    add_pkt(2, 3, 8'hA1, 1'b0);
    run_until_idle(50);
    check_eq("single_hdr_count", 32'(hdr_log.size()), 32'd1);
    check_eq("single_hdr", 32'(hdr_log[0]), 32'h02);

    // truncation at MAXL beats, then tlast exactly on the limit
    hdr_log.delete(); trunc_seen = 0;
    add_pkt(1, 6, 8'h30, 1'b0);
    run_until_idle(60);
    check_eq("trunc_pulses", 32'(trunc_seen), 32'd1);
    check_eq("trunc_hdr_count", 32'(hdr_log.size()), 32'd2);
    check_eq("trunc_hdr1", 32'(hdr_log[1]), 32'h01);
    trunc_seen = 0;
    add_pkt(1, 4, 8'h50, 1'b0);
    run_until_idle(60);
    check_eq("limit_last_pulses", 32'(trunc_seen), 32'd0);

    // backpressure on a single packet
    full_pct = 50;
    add_pkt(2, 5, 8'h60, 1'b0);
    run_until_idle(200);
    full_pct = 0;

    // stalled requester must not let another one interleave
    hdr_log.delete();
    stall_arm = 1'b1;
    add_pkt(0, 4, 8'h70, 1'b0);
    cycle(); cycle(); cycle();
    add_pkt(3, 2, 8'h80, 1'b0);
    run_until_idle(100);
    check_eq("stall_hdr_count", 32'(hdr_log.size()), 32'd2);
    check_eq("stall_hdr0", 32'(hdr_log[0]), 32'h00);
    check_eq("stall_hdr1", 32'(hdr_log[1]), 32'h03);

    // randomized traffic with gaps and backpressure
    gap_pct = 30; full_pct = 25;
    for (int p = 0; p < 60; p++) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 7), 8'h00, 1'b1);
    run_until_idle(5000);
    gap_pct = 0; full_pct = 0;

    // reset in the middle of a packet
    add_pkt(1, 5, 8'h90, 1'b0);
    for (int c = 0; c < 20 && !(m_phase == 2 && m_beats == 1); c++) cycle();
    check_eq("midrst_reached_data", 32'(m_phase == 2 && m_beats == 1), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_tready", 32'(s_tready), 32'h0);
    check_eq("midrst_fifo_wr", 32'(fifo_wr), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    check_eq("midrst_grant", 32'(grant_id), 32'h0);
    for (int k = 0; k < N; k++) begin src_q[k].delete(); acc[k] = 1'b0; end
    s_tvalid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    hdr_log.delete();
    add_pkt(3, 1, 8'hC3, 1'b0);
    add_pkt(0, 1, 8'hC0, 1'b0);
    run_until_idle(50);
    check_eq("postrst_hdr0", 32'(hdr_log[0]), 32'h00);
    check_eq("postrst_hdr1", 32'(hdr_log[1]), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
